// File: rtl/timing_gen_pkg.sv
// Shared types for the timing generator: channel FSM states and per-channel config.
// With TG_POL_INVERT_EN defined, the config record also carries an output polarity bit.
package timing_gen_pkg;

  localparam int TG_N      = 28;
  localparam int TG_BW     = 8;
  localparam int BURST_INF = 0;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    DELAY,
    ACTIVE
  } ch_state_t;

  // Field widths follow TG_N/TG_BW; the top-level N/BW parameters must match them.
  typedef struct packed {
    logic [TG_N-1:0]  delay;
    logic [TG_N-1:0]  width;
    logic [TG_BW-1:0] burst;
`ifdef TG_POL_INVERT_EN
    logic             pol;
`endif
  } ch_cfg_t;

endpackage

// File: rtl/pulse_channel.sv
// One output channel: tick -> D cycles -> W-cycle pulse, repeated for a burst or forever.
// The pulse rises on edge T0+D and falls on edge T0+D+W; no backpressure, late ticks raise overrun.
module pulse_channel
  import timing_gen_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_i,
  input  logic             run_i,
  input  logic             run_rise_i,
  input  logic [TG_N-1:0]  delay_i,
  input  logic [TG_N-1:0]  width_i,
  input  logic [TG_BW-1:0] burst_i,
  output logic             pulse_o,
  output logic             busy_o,
  output logic             overrun_o,
  output logic             en_o,
  output logic             inf_o,
  output logic             cmp_o
);

  ch_state_t        state_q;
  logic [TG_N-1:0]  cnt_q;
  logic [TG_N-1:0]  wid_q;
  logic [TG_BW-1:0] rem_q;
  logic             pulse_q;
  logic             ovr_q;
  logic             en_q;
  logic             inf_q;
  logic             cmp_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wid_q   <= '0;
      rem_q   <= '0;
      pulse_q <= 1'b0;
      ovr_q   <= 1'b0;
      en_q    <= 1'b0;
      inf_q   <= 1'b0;
      cmp_q   <= 1'b0;
    end else if (!run_i) begin
      // Overrun stays visible after a stop; it only clears on the next start.
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      pulse_q <= 1'b0;
      en_q    <= 1'b0;
      inf_q   <= 1'b0;
      cmp_q   <= 1'b0;
    end else if (run_rise_i) begin
      state_q <= (width_i != '0) ? ARMED : IDLE;
      rem_q   <= burst_i;
      pulse_q <= 1'b0;
      ovr_q   <= 1'b0;
      en_q    <= (width_i != '0);
      inf_q   <= (burst_i == TG_BW'(BURST_INF));
      cmp_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
        end
        ARMED: begin
          if (tick_i) begin
            if (width_i == '0) begin
              state_q <= IDLE;
              en_q    <= 1'b0;
            end else if (delay_i == '0) begin
              state_q <= ACTIVE;
              pulse_q <= 1'b1;
              cnt_q   <= width_i;
            end else begin
              state_q <= DELAY;
              cnt_q   <= delay_i;
              wid_q   <= width_i;
            end
          end
        end
        DELAY: begin
          if (tick_i) ovr_q <= 1'b1;
          if (cnt_q == TG_N'(1)) begin
            state_q <= ACTIVE;
            pulse_q <= 1'b1;
            cnt_q   <= wid_q;
          end else begin
            cnt_q <= cnt_q - TG_N'(1);
          end
        end
        ACTIVE: begin
          if (tick_i) ovr_q <= 1'b1;
          if (cnt_q == TG_N'(1)) begin
            pulse_q <= 1'b0;
            if (!inf_q && rem_q == TG_BW'(1)) begin
              state_q <= IDLE;
              cmp_q   <= 1'b1;
            end else begin
              state_q <= ARMED;
              if (!inf_q) rem_q <= rem_q - TG_BW'(1);
            end
          end else begin
            cnt_q <= cnt_q - TG_N'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pulse_o   = pulse_q;
  assign busy_o    = (state_q != IDLE);
  assign overrun_o = ovr_q;
  assign en_o      = en_q;
  assign inf_o     = inf_q;
  assign cmp_o     = cmp_q;

endmodule

// File: rtl/pulse_sequencer.sv
// NCH-channel programmable pulse generator driven by the period counter's carry tick.
// Config writes land on the next edge; TG_POL_INVERT_EN adds cfg_pol for per-channel output inversion.
module pulse_sequencer
  import timing_gen_pkg::*;
#(
  parameter int N   = TG_N,
  parameter int NCH = 4,
  parameter int BW  = TG_BW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   period_tick,
  input  logic                   run,
  input  logic                   cfg_we,
  input  logic [$clog2(NCH)-1:0] cfg_ch,
  input  logic [N-1:0]           cfg_delay,
  input  logic [N-1:0]           cfg_width,
  input  logic [BW-1:0]          cfg_burst,
`ifdef TG_POL_INVERT_EN
  input  logic                   cfg_pol,
`endif
  output logic [NCH-1:0]         pulse_out,
  output logic [NCH-1:0]         busy,
  output logic [NCH-1:0]         overrun,
  output logic                   done
);

  ch_cfg_t        cfg_q [NCH];
  ch_cfg_t        wr_cfg;
  logic           run_q;
  logic           run_rise;
  logic [NCH-1:0] act;
  logic [NCH-1:0] en;
  logic [NCH-1:0] inf;
  logic [NCH-1:0] cmp;
  logic [NCH-1:0] fin;

  always_comb begin
    wr_cfg       = '0;
    wr_cfg.delay = cfg_delay;
    wr_cfg.width = cfg_width;
    wr_cfg.burst = cfg_burst;
`ifdef TG_POL_INVERT_EN
    wr_cfg.pol   = cfg_pol;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) cfg_q[i] <= '0;
    end else if (cfg_we) begin
      for (int i = 0; i < NCH; i++) begin
        if (int'(cfg_ch) == i) cfg_q[i] <= wr_cfg;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) run_q <= 1'b0;
    else       run_q <= run;
  end

  assign run_rise = run && !run_q;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    pulse_channel u_ch (
      .clk       (clk),
      .reset     (reset),
      .tick_i    (period_tick),
      .run_i     (run),
      .run_rise_i(run_rise),
      .delay_i   (cfg_q[c].delay),
      .width_i   (cfg_q[c].width),
      .burst_i   (cfg_q[c].burst),
      .pulse_o   (act[c]),
      .busy_o    (busy[c]),
      .overrun_o (overrun[c]),
      .en_o      (en[c]),
      .inf_o     (inf[c]),
      .cmp_o     (cmp[c])
    );
`ifdef TG_POL_INVERT_EN
    assign pulse_out[c] = act[c] ^ cfg_q[c].pol;
`else
    assign pulse_out[c] = act[c];
`endif
  end

  // Any enabled infinite channel, or no finite one at all, keeps done low.
  always_comb begin
    fin  = en & ~inf;
    done = (|fin) && !(|(en & inf)) && ((fin & ~cmp) == '0);
  end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Randomised scoreboard bench for pulse_sequencer: a tick-level model predicts each pulse's
// rise edge and width plus final overrun/busy/done; a negedge monitor checks observed pulses.
module tb_pulse_sequencer;

  localparam int N   = 28;
  localparam int NCH = 4;
  localparam int BW  = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           period_tick = 1'b0;
  logic           run = 1'b0;
  logic           cfg_we = 1'b0;
  logic [1:0]     cfg_ch = '0;
  logic [N-1:0]   cfg_delay = '0;
  logic [N-1:0]   cfg_width = '0;
  logic [BW-1:0]  cfg_burst = '0;
`ifdef TG_POL_INVERT_EN
  logic           cfg_pol = 1'b0;
`endif
  logic [NCH-1:0] pulse_out;
  logic [NCH-1:0] busy;
  logic [NCH-1:0] overrun;
  logic           done;

  pulse_sequencer #(.N(N), .NCH(NCH), .BW(BW)) dut (
    .clk        (clk),
    .reset      (reset),
    .period_tick(period_tick),
    .run        (run),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_delay  (cfg_delay),
    .cfg_width  (cfg_width),
    .cfg_burst  (cfg_burst),
`ifdef TG_POL_INVERT_EN
    .cfg_pol    (cfg_pol),
`endif
    .pulse_out  (pulse_out),
    .busy       (busy),
    .overrun    (overrun),
    .done       (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int ch;
    int rise;
    int width;
  } pulse_t;

  pulse_t         expq[$];
  int             checks = 0;
  int             failures = 0;
  bit             mon_on = 1'b0;
  logic [NCH-1:0] pol_m = '0;
  int             d[NCH];
  int             w[NCH];
  int             b[NCH];

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void check_pulse(input int c, input int r, input int wd);
    int idx;
    idx = -1;
    for (int i = 0; i < expq.size(); i++) begin
      if (expq[i].ch == c) begin
        idx = i;
        break;
      end
    end
    if (idx < 0) begin
      checks++;
      failures++;
      $display("FAIL pulse_unexpected ch=%0d actual rise=%0d width=%0d expected no pulse", c, r, wd);
    end else begin
      chk($sformatf("pulse_rise_ch%0d", c), r, expq[idx].rise);
      chk($sformatf("pulse_width_ch%0d", c), wd, expq[idx].width);
      expq.delete(idx);
    end
  endfunction

  // Monitor: value seen at the negedge after edge e is the post-edge-e level.
  logic [NCH-1:0] prev_lv = '0;
  int             rise_at [NCH];
  always @(negedge clk) begin
    logic [NCH-1:0] lv;
    lv = pulse_out ^ pol_m;
    for (int c = 0; c < NCH; c++) begin
      if (lv[c] && !prev_lv[c]) rise_at[c] = cyc;
      if (!lv[c] && prev_lv[c] && mon_on) check_pulse(c, rise_at[c], cyc - rise_at[c]);
    end
    prev_lv = lv;
  end

  task automatic wr(input int c, input int dd, input int ww, input int bb);
    d[c] = dd;
    w[c] = ww;
    b[c] = bb;
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_ch    = c[1:0];
    cfg_delay = N'(dd);
    cfg_width = N'(ww);
    cfg_burst = BW'(bb);
`ifdef TG_POL_INVERT_EN
    cfg_pol   = pol_m[c];
`endif
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // A tick sampled at edge e is accepted when the channel is armed: after the run edge R,
  // after the previous pulse has ended (e > T0+D+W) and with burst left. Ticks inside a
  // previous pulse window are overruns.
  task automatic do_run(input int P, input int nticks, input bit tick_at_rise);
    int R, nxt, mx, e;
    int last_end[NCH];
    int rem[NCH];
    bit ovr[NCH];
    bit fin_any, inf_any, all_cmp;
    pulse_t p;
    mx = 0;
    for (int c = 0; c < NCH; c++) begin
      rem[c] = b[c];
      ovr[c] = 1'b0;
      if (d[c] + w[c] > mx) mx = d[c] + w[c];
    end
    @(negedge clk);
    run = 1'b1;
    R = cyc + 1;
    period_tick = tick_at_rise;
    for (int c = 0; c < NCH; c++) last_end[c] = R;
    nxt = R + 1 + int'($urandom_range(0, 3));
    @(negedge clk);
    period_tick = 1'b0;
    for (int k = 0; k < nticks; k++) begin
      while (cyc + 1 < nxt) @(negedge clk);
      e = cyc + 1;
      period_tick = 1'b1;
      for (int c = 0; c < NCH; c++) begin
        if (w[c] != 0) begin
          if (e <= last_end[c]) begin
            ovr[c] = 1'b1;
          end else if (b[c] == 0 || rem[c] > 0) begin
            p.ch = c;
            p.rise = e + d[c];
            p.width = w[c];
            expq.push_back(p);
            last_end[c] = e + d[c] + w[c];
            if (b[c] != 0) rem[c]--;
          end
        end
      end
      @(negedge clk);
      period_tick = 1'b0;
      nxt += P;
    end
    repeat (mx + 3) @(negedge clk);
    fin_any = 1'b0;
    inf_any = 1'b0;
    all_cmp = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("overrun_ch%0d", c), int'(overrun[c]), int'(ovr[c]));
      chk($sformatf("busy_ch%0d", c), int'(busy[c]), int'((w[c] != 0) && (b[c] == 0 || rem[c] > 0)));
      if (w[c] != 0) begin
        if (b[c] == 0) inf_any = 1'b1;
        else begin
          fin_any = 1'b1;
          if (rem[c] > 0) all_cmp = 1'b0;
        end
      end
    end
    chk("done", int'(done), int'(fin_any && !inf_any && all_cmp));
    chk("pulses_outstanding", expq.size(), 0);
    expq.delete();
    run = 1'b0;
    @(negedge clk);
    chk("stop_busy", int'(busy), 0);
    chk("stop_done", int'(done), 0);
    chk("stop_pulse_idle", int'(pulse_out ^ pol_m), 0);
  endtask

  task automatic start_and_tick();
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    period_tick = 1'b1;
    @(negedge clk);
    period_tick = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int c = 0; c < NCH; c++) begin
      d[c] = 0;
      w[c] = 0;
      b[c] = 0;
    end
    repeat (3) @(negedge clk);
    chk("reset_pulse_out", int'(pulse_out), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_overrun", int'(overrun), 0);
    chk("reset_done", int'(done), 0);
    reset = 1'b0;
    @(negedge clk);
    mon_on = 1'b1;

    // Single pulse, then done.
    wr(0, 2, 3, 1); wr(1, 0, 0, 0); wr(2, 0, 0, 0); wr(3, 0, 0, 0);
    do_run(10, 3, 1'b0);
    // D=0 infinite on ch1: pulse every tick, done stays low.
    wr(0, 0, 0, 0); wr(1, 0, 1, 0);
    do_run(10, 5, 1'b0);
    // Burst of 3 on ch2, fourth tick produces nothing.
    wr(1, 0, 0, 0); wr(2, 1, 2, 3);
    do_run(8, 4, 1'b0);
    // D+W equal to the period: every other tick is an overrun.
    wr(2, 0, 0, 0); wr(0, 2, 3, 0);
    do_run(5, 6, 1'b1);

    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < NCH; c++)
        wr(c, int'($urandom_range(0, 6)), int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
      do_run(int'($urandom_range(4, 12)), int'($urandom_range(3, 8)), 1'($urandom_range(0, 1)));
    end

    // Abort mid-pulse by dropping run.
    mon_on = 1'b0;
    wr(0, 1, 10, 0); wr(1, 0, 0, 0); wr(2, 0, 0, 0); wr(3, 0, 0, 0);
    start_and_tick();
    for (int i = 0; i < 20 && !pulse_out[0]; i++) @(negedge clk);
    chk("abort_pulse_started", int'(pulse_out[0]), 1);
    run = 1'b0;
    @(negedge clk);
    chk("abort_pulse_low", int'(pulse_out), 0);
    chk("abort_busy", int'(busy), 0);

    // Reset during DELAY clears everything without waiting for a clock edge.
    wr(0, 8, 2, 1);
    start_and_tick();
    repeat (2) @(negedge clk);
    chk("delay_busy", int'(busy[0]), 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_delay_pulse", int'(pulse_out), 0);
    chk("rst_delay_busy", int'(busy), 0);
    chk("rst_delay_overrun", int'(overrun), 0);
    chk("rst_delay_done", int'(done), 0);
    run = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Reset during ACTIVE drops the pulse asynchronously.
    wr(0, 1, 6, 1);
    start_and_tick();
    for (int i = 0; i < 20 && !pulse_out[0]; i++) @(negedge clk);
    chk("active_pulse_started", int'(pulse_out[0]), 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_active_pulse", int'(pulse_out), 0);
    run = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Reset cleared all config: a run now produces nothing and done stays low.
    for (int c = 0; c < NCH; c++) begin
      d[c] = 0;
      w[c] = 0;
      b[c] = 0;
    end
    mon_on = 1'b1;
    do_run(6, 2, 1'b0);

`ifdef TG_POL_INVERT_EN
    mon_on = 1'b0;
    pol_m[0] = 1'b1;
    wr(0, 1, 2, 1);
    @(negedge clk);
    chk("pol_idle_high", int'(pulse_out[0]), 1);
    @(negedge clk);
    mon_on = 1'b1;
    do_run(8, 2, 1'b0);
    mon_on = 1'b0;
    pol_m[0] = 1'b0;
    wr(0, 0, 0, 0);
    repeat (2) @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
